// File: rtl/pm_pkg.sv
// Shared types for the memory-bridge power controller: channel power state
// encoding and elaboration helpers for parameter sanity checks.
package pm_pkg;

    typedef enum logic [1:0] {
        PM_ACTIVE       = 2'd0,
        PM_POWER_DOWN   = 2'd1,
        PM_SELF_REFRESH = 2'd2,
        PM_EXIT         = 2'd3
    } pm_state_e;

    localparam logic [1:0] PM_ENC_ACTIVE       = 2'd0;
    localparam logic [1:0] PM_ENC_POWER_DOWN   = 2'd1;
    localparam logic [1:0] PM_ENC_SELF_REFRESH = 2'd2;
    localparam logic [1:0] PM_ENC_EXIT         = 2'd3;

    function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // True when value is representable in an unsigned field of the given width.
    function automatic bit fits_width(input int unsigned value, input int unsigned width);
        longint unsigned limit;
        if (width >= 32) return 1'b1;
        limit = (longint'(1) << width) - 1;
        return (longint'(value) <= limit);
    endfunction

endpackage

// File: rtl/pm_channel_fsm.sv
// One memory channel's power FSM: idle counting, power-down/self-refresh
// entry and timed wake-up. Effective power-down threshold comes from the top.
module pm_channel_fsm
    import pm_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned SR_IDLE_CYCLES = 64,
    parameter int unsigned PD_EXIT_CYCLES = 4,
    parameter int unsigned SR_EXIT_CYCLES = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    input  logic             pd_enable,
    input  logic             sr_enable,
    input  logic [CNT_W-1:0] pd_thr,
    output logic             cmd_ready,
    output logic [1:0]       state,
    output logic             pd_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SR_IDLE_THR = CNT_W'(SR_IDLE_CYCLES);
    localparam logic [CNT_W-1:0] PD_EXIT_CNT = CNT_W'(PD_EXIT_CYCLES);
    localparam logic [CNT_W-1:0] SR_EXIT_CNT = CNT_W'(SR_EXIT_CYCLES);

    pm_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pd_ready_reg, pd_ready_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= PM_ACTIVE;
            cnt_reg      <= '0;
            pd_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pd_ready_reg <= pd_ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pd_ready_next = pd_ready_reg;
        unique case (state_reg)
            PM_ACTIVE: begin
                // A pending command always beats threshold and entry.
                if (cmd_valid) begin
                    cnt_next      = '0;
                    pd_ready_next = 1'b0;
                end else if (pd_enable && pd_ready_reg) begin
                    state_next    = PM_POWER_DOWN;
                    cnt_next      = '0;
                    pd_ready_next = 1'b0;
                end else begin
                    cnt_next      = (cnt_reg >= pd_thr) ? cnt_reg : cnt_reg + CNT_ONE;
                    pd_ready_next = (cnt_next >= pd_thr);
                end
            end
            PM_POWER_DOWN: begin
                if (cmd_valid) begin
                    state_next = PM_EXIT;
                    cnt_next   = PD_EXIT_CNT;
                end else begin
                    cnt_next = (cnt_reg >= SR_IDLE_THR) ? cnt_reg : cnt_reg + CNT_ONE;
                    if (sr_enable && (cnt_next >= SR_IDLE_THR)) begin
                        state_next = PM_SELF_REFRESH;
                        cnt_next   = '0;
                    end
                end
            end
            PM_SELF_REFRESH: begin
                if (cmd_valid) begin
                    state_next = PM_EXIT;
                    cnt_next   = SR_EXIT_CNT;
                end
            end
            PM_EXIT: begin
                // Leaving on the decrement to zero gives N+1 cycles to cmd_ready.
                if (cnt_reg <= CNT_ONE) begin
                    state_next    = PM_ACTIVE;
                    cnt_next      = '0;
                    pd_ready_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
        endcase
    end

    assign cmd_ready = (state_reg == PM_ACTIVE);
    assign state     = state_reg;
    assign pd_ready  = pd_ready_reg;

endmodule

// File: rtl/pm_multichannel_ctrl.sv
// Multichannel power-management controller: thermal hysteresis flag shared by
// NUM_CH independent channel FSMs whose states are packed onto power_state.
module pm_multichannel_ctrl
    import pm_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned PD_IDLE_CYCLES = 16,
    parameter int unsigned SR_IDLE_CYCLES = 64,
    parameter int unsigned PD_EXIT_CYCLES = 4,
    parameter int unsigned SR_EXIT_CYCLES = 12,
    parameter int unsigned TEMP_W         = 8,
    parameter int unsigned TEMP_HI        = 70,
    parameter int unsigned TEMP_LO        = 65
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NUM_CH-1:0]     cmd_valid,
    output logic [NUM_CH-1:0]     cmd_ready,
    input  logic                  pd_enable,
    input  logic                  sr_enable,
    input  logic [TEMP_W-1:0]     temperature,
    output logic [2*NUM_CH-1:0]   power_state,
    output logic [NUM_CH-1:0]     pd_ready,
    output logic                  low_power_mode
);

    localparam int unsigned      PD_IDLE_LP   = ((PD_IDLE_CYCLES >> 2) == 0) ? 1 : (PD_IDLE_CYCLES >> 2);
    localparam logic [CNT_W-1:0] PD_THR_NORM  = CNT_W'(PD_IDLE_CYCLES);
    localparam logic [CNT_W-1:0] PD_THR_LP    = CNT_W'(PD_IDLE_LP);
    localparam logic [TEMP_W-1:0] TEMP_HI_T   = TEMP_W'(TEMP_HI);
    localparam logic [TEMP_W-1:0] TEMP_LO_T   = TEMP_W'(TEMP_LO);

    generate
        if (!fits_width(max_cycles(PD_IDLE_CYCLES, SR_IDLE_CYCLES, PD_EXIT_CYCLES, SR_EXIT_CYCLES), CNT_W)) begin : g_cnt_w_bad
            $error("CNT_W too narrow for the configured cycle counts");
        end
        if (TEMP_LO > TEMP_HI) begin : g_temp_bad
            $error("TEMP_LO must not exceed TEMP_HI");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_num_ch_bad
            $error("NUM_CH must be within 1..8");
        end
    endgenerate

    logic             low_power_mode_reg, low_power_mode_next;
    logic [CNT_W-1:0] pd_thr;

    // Hysteresis: set at or above HI, clear below LO, hold in between.
    always_comb begin
        low_power_mode_next = low_power_mode_reg;
        if (temperature >= TEMP_HI_T) begin
            low_power_mode_next = 1'b1;
        end else if (temperature < TEMP_LO_T) begin
            low_power_mode_next = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            low_power_mode_reg <= 1'b0;
        end else begin
            low_power_mode_reg <= low_power_mode_next;
        end
    end

    assign pd_thr         = low_power_mode_reg ? PD_THR_LP : PD_THR_NORM;
    assign low_power_mode = low_power_mode_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pm_channel_fsm #(
                .CNT_W          (CNT_W),
                .SR_IDLE_CYCLES (SR_IDLE_CYCLES),
                .PD_EXIT_CYCLES (PD_EXIT_CYCLES),
                .SR_EXIT_CYCLES (SR_EXIT_CYCLES)
            ) u_ch (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .cmd_valid (cmd_valid[gi]),
                .pd_enable (pd_enable),
                .sr_enable (sr_enable),
                .pd_thr    (pd_thr),
                .cmd_ready (cmd_ready[gi]),
                .state     (power_state[2*gi +: 2]),
                .pd_ready  (pd_ready[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pm_multichannel_ctrl.sv
// Scoreboard bench for pm_multichannel_ctrl: a cycle-level behavioural model
// queues expected outputs, a monitor compares them after every clock edge.
module tb_pm_multichannel_ctrl;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 16;
    localparam int PD_IDLE = 16;
    localparam int SR_IDLE = 64;
    localparam int PD_EXIT = 4;
    localparam int SR_EXIT = 12;
    localparam int TEMP_W  = 8;
    localparam int TEMP_HI = 70;
    localparam int TEMP_LO = 65;
    localparam int PD_LP   = ((PD_IDLE / 4) < 1) ? 1 : (PD_IDLE / 4);

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [NUM_CH-1:0]   cmd_valid = '0;
    logic [NUM_CH-1:0]   cmd_ready;
    logic                pd_enable = 1'b0;
    logic                sr_enable = 1'b0;
    logic [TEMP_W-1:0]   temperature = '0;
    logic [2*NUM_CH-1:0] power_state;
    logic [NUM_CH-1:0]   pd_ready;
    logic                low_power_mode;

    always #5 sys_clk = ~sys_clk;

    pm_multichannel_ctrl #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PD_IDLE_CYCLES(PD_IDLE), .SR_IDLE_CYCLES(SR_IDLE),
        .PD_EXIT_CYCLES(PD_EXIT), .SR_EXIT_CYCLES(SR_EXIT), .TEMP_W(TEMP_W),
        .TEMP_HI(TEMP_HI), .TEMP_LO(TEMP_LO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .pd_enable(pd_enable), .sr_enable(sr_enable), .temperature(temperature),
        .power_state(power_state), .pd_ready(pd_ready), .low_power_mode(low_power_mode)
    );

    typedef struct packed {
        logic [2*NUM_CH-1:0] ps;
        logic [NUM_CH-1:0]   pdr;
        logic                lpm;
        logic [NUM_CH-1:0]   crdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: 0=active 1=power-down 2=self-refresh 3=exit.
    int m_state[NUM_CH];
    int m_idle[NUM_CH];
    bit m_rdy[NUM_CH];
    int m_pd_start[NUM_CH];
    int m_wake[NUM_CH];
    bit m_lpm;
    int cyc;

    bit req[NUM_CH];
    bit acc[NUM_CH];
    int prob[NUM_CH];
    bit pulse0;
    bit pd_en_s;
    bit sr_en_s;
    int temp_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_state[ch] = 0; m_idle[ch] = 0; m_rdy[ch] = 0;
            m_pd_start[ch] = 0; m_wake[ch] = 0; req[ch] = 0; acc[ch] = 0;
        end
        m_lpm = 0;
        cyc = 0;
        pulse0 = 0;
    endtask

    // Drive inputs for the coming edge and queue what the outputs must become.
    task automatic drive_and_model();
        exp_t e;
        int   thr;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (acc[ch]) req[ch] = 1'b0;
            if (!req[ch] && int'($urandom_range(99)) < prob[ch]) req[ch] = 1'b1;
        end
        if (pulse0) begin
            req[0] = 1'b1;
            pulse0 = 1'b0;
        end
        for (int ch = 0; ch < NUM_CH; ch++) cmd_valid[ch] = req[ch];
        pd_enable   = pd_en_s;
        sr_enable   = sr_en_s;
        temperature = TEMP_W'(temp_s);
        cyc++;
        thr = m_lpm ? PD_LP : PD_IDLE;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc[ch] = 1'b0;
            case (m_state[ch])
                0: begin
                    if (req[ch]) begin
                        acc[ch] = 1'b1;
                        m_idle[ch] = 0;
                        m_rdy[ch] = 0;
                        $display("cycle %0d: ch%0d command accepted", cyc, ch);
                    end else if (pd_en_s && m_rdy[ch]) begin
                        m_state[ch] = 1; m_pd_start[ch] = cyc; m_idle[ch] = 0; m_rdy[ch] = 0;
                    end else begin
                        if (m_idle[ch] < thr) m_idle[ch]++;
                        m_rdy[ch] = (m_idle[ch] >= thr);
                    end
                end
                1: begin
                    if (req[ch]) begin
                        m_state[ch] = 3; m_wake[ch] = cyc + PD_EXIT;
                    end else if (sr_en_s && (cyc - m_pd_start[ch]) >= SR_IDLE) begin
                        m_state[ch] = 2;
                    end
                end
                2: begin
                    if (req[ch]) begin
                        m_state[ch] = 3; m_wake[ch] = cyc + SR_EXIT;
                    end
                end
                default: begin
                    if (cyc >= m_wake[ch]) begin
                        m_state[ch] = 0; m_idle[ch] = 0; m_rdy[ch] = 0;
                    end
                end
            endcase
        end
        if (temp_s >= TEMP_HI) m_lpm = 1'b1;
        else if (temp_s < TEMP_LO) m_lpm = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e.ps[2*ch +: 2] = 2'(m_state[ch]);
            e.pdr[ch]       = m_rdy[ch];
            e.crdy[ch]      = (m_state[ch] == 0);
        end
        e.lpm = m_lpm;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge sys_clk);
        drive_and_model();
    endtask

    task automatic settle();
        @(posedge sys_clk);
        #2;
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
    task automatic apply_reset(input string tag);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check({tag, "_power_state"}, 32'(power_state), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'({NUM_CH{1'b1}}));
        check({tag, "_pd_ready"}, 32'(pd_ready), 32'd0);
        check({tag, "_low_power_mode"}, 32'(low_power_mode), 32'd0);
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drive_and_model();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("power_state", 32'(power_state), 32'(e.ps));
                check("pd_ready", 32'(pd_ready), 32'(e.pdr));
                check("low_power_mode", 32'(low_power_mode), 32'(e.lpm));
                check("cmd_ready", 32'(cmd_ready), 32'(e.crdy));
            end
        end
    end

    initial begin : stimulus
        int n;
        bit done;
        model_reset();
        pd_en_s = 1; sr_en_s = 1; temp_s = 60;
        prob[0] = 0; prob[1] = 100;

        // Idle channel 0 walks ACTIVE -> POWER_DOWN -> SELF_REFRESH, channel 1 busy.
        apply_reset("rst_initial");
        repeat (15) step();
        settle();
        check("pd_ready_after_16_idle", 32'(pd_ready[0]), 32'd1);
        check("still_active_at_threshold", 32'(power_state[1:0]), 32'd0);
        step(); settle();
        check("enter_power_down", 32'(power_state[1:0]), 32'd1);
        check("cmd_ready_in_pd", 32'(cmd_ready[0]), 32'd0);
        repeat (63) step();
        settle();
        check("pd_before_sr", 32'(power_state[1:0]), 32'd1);
        step(); settle();
        check("enter_self_refresh", 32'(power_state[1:0]), 32'd2);
        check("busy_ch1_active", 32'(power_state[3:2]), 32'd0);

        // Wake from self-refresh with a held command.
        prob[0] = 100;
        n = 0; done = 0;
        while (!done && n < 40) begin
            step(); n++;
            settle();
            if (cmd_ready[0]) done = 1;
        end
        check("sr_exit_latency", 32'(n), 32'(SR_EXIT + 1));

        // Command on the cycle the threshold would be reached.
        prob[0] = 0; prob[1] = 0;
        apply_reset("rst_pulse");
        repeat (14) step();
        pulse0 = 1;
        step(); settle();
        check("pulse_pd_ready_cleared", 32'(pd_ready[0]), 32'd0);
        check("pulse_stays_active", 32'(power_state[1:0]), 32'd0);
        repeat (15) step();
        settle();
        check("restart_not_ready", 32'(pd_ready[0]), 32'd0);
        step(); settle();
        check("restart_ready", 32'(pd_ready[0]), 32'd1);

        // Thermal hysteresis 60 -> 72 -> 67 -> 64 and the shortened threshold.
        temp_s = 60;
        apply_reset("rst_thermal");
        settle();
        check("lpm_at_60", 32'(low_power_mode), 32'd0);
        temp_s = 72; step(); settle();
        check("lpm_at_72", 32'(low_power_mode), 32'd1);
        temp_s = 67; step(); step(); settle();
        check("lp_pd_ready_early", 32'(pd_ready[0]), 32'd1);
        step(); settle();
        check("lp_enter_pd", 32'(power_state[1:0]), 32'd1);
        check("lpm_at_67", 32'(low_power_mode), 32'd1);
        temp_s = 64; step(); settle();
        check("lpm_at_64", 32'(low_power_mode), 32'd0);

        // Reset while channel 0 is waking.
        prob[0] = 100;
        step(); step(); settle();
        check("in_exit_before_reset", 32'(power_state[1:0]), 32'd3);
        prob[0] = 0;
        apply_reset("rst_mid_exit");

        // Randomised traffic, policy and temperature.
        for (int ph = 0; ph < 20; ph++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case ($urandom_range(3))
                    0: prob[ch] = 0;
                    1: prob[ch] = 1;
                    2: prob[ch] = 4;
                    default: prob[ch] = 30;
                endcase
            end
            pd_en_s = ($urandom_range(3) != 0);
            sr_en_s = ($urandom_range(3) != 0);
            for (int k = 0; k < 200; k++) begin
                temp_s = temp_s + int'($urandom_range(6)) - 3;
                if (temp_s < 50) temp_s = 50;
                if (temp_s > 90) temp_s = 90;
                step();
            end
        end
        settle();
        settle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
